// File: rtl/dispatch_pkg.sv
// Shared FU class encoding and default widths for the dispatch buffer slice.
// Latency: n/a (types and constants only). Backpressure: n/a.
// No logic; imported by dispatch_select and dispatch_buffer.
package dispatch_pkg;

    typedef enum logic [2:0] {
        FU_ALU1 = 3'd0,
        FU_ALU2 = 3'd1,
        FU_BRU  = 3'd2,
        FU_CSRU = 3'd3,
        FU_DIV  = 3'd4,
        FU_MUL  = 3'd5,
        FU_LSU  = 3'd6
    } fu_class_e;

    localparam int DEF_PAYLOAD_W = 96;
    localparam int DEF_ROB_CNT_W = 7;

endpackage

// File: rtl/dispatch_select.sv
// In-order issue selection over the oldest WAYS queue slots.
// Latency: purely combinational. Backpressure: stops at the first slot blocked by RS full, FU conflict or ROB space.
// Younger slots never bypass a blocked older slot.
module dispatch_select
    import dispatch_pkg::*;
#(
    parameter int WAYS      = 4,
    parameter int FU_NUM    = 7,
    parameter int FU_IDX_W  = 3,
    parameter int ROB_CNT_W = DEF_ROB_CNT_W,
    parameter int CNT_W     = 4,
    parameter int ISS_W     = $clog2(WAYS + 1)
) (
    input  logic [WAYS*FU_IDX_W-1:0] cand_fu,
    input  logic [FU_NUM-1:0]        fu_full,
    input  logic [ROB_CNT_W-1:0]     rob_free,
    input  logic [CNT_W-1:0]         count,
    output logic [WAYS-1:0]          issue_mask,
    output logic [ISS_W-1:0]         issue_cnt
);

    logic [FU_NUM-1:0]   used;
    logic [FU_IDX_W-1:0] fu;
    logic                go;

    always_comb begin
        used       = '0;
        fu         = '0;
        go         = 1'b1;
        issue_mask = '0;
        issue_cnt  = '0;
        for (int i = 0; i < WAYS; i++) begin
            fu = cand_fu[i*FU_IDX_W +: FU_IDX_W];
            // Out-of-range FU classes are treated as permanently blocked.
            if (go && (int'(count) > i) && (int'(rob_free) > i) &&
                (int'(fu) < FU_NUM) && !fu_full[fu] && !used[fu]) begin
                used[fu]      = 1'b1;
                issue_mask[i] = 1'b1;
                issue_cnt     = issue_cnt + ISS_W'(1);
            end else begin
                go = 1'b0;
            end
        end
    end

endmodule

// File: rtl/dispatch_buffer.sv
// Circular in-order dispatch queue between rename and RS/ROB; optional stall counters under DISPATCH_STAT_EN.
// Latency: bundle accepted at edge N may issue in cycle N+1; issue outputs are combinational from queue state.
// Backpressure: InReady only when WAYS free slots exist (registered count) and no flush; issue gated by FuFull/RobFreeNumb.
module dispatch_buffer
    import dispatch_pkg::*;
#(
    parameter int WAYS      = 4,
    parameter int DEPTH     = 8,
    parameter int PAYLOAD_W = DEF_PAYLOAD_W,
    parameter int FU_NUM    = 7,
    parameter int FU_IDX_W  = 3,
    parameter int ROB_CNT_W = DEF_ROB_CNT_W
) (
    input  logic                      Clk,
    input  logic                      Rest,
    input  logic                      DispatchFlash,
    input  logic [WAYS-1:0]           InValid,
    input  logic [WAYS*PAYLOAD_W-1:0] InPayload,
    input  logic [WAYS*FU_IDX_W-1:0]  InFu,
    output logic                      InReady,
    output logic                      DispatchStop,
    input  logic [ROB_CNT_W-1:0]      RobFreeNumb,
    output logic [WAYS-1:0]           RobAllocValid,
    output logic [WAYS*PAYLOAD_W-1:0] RobAllocPayload,
    output logic [FU_NUM-1:0]         FuValid,
    output logic [FU_NUM*PAYLOAD_W-1:0] FuPayload,
    input  logic [FU_NUM-1:0]         FuFull,
    output logic [31:0]               StallRobCnt,
    output logic [31:0]               StallRsCnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ISS_W = $clog2(WAYS + 1);

    logic [PAYLOAD_W-1:0]    mem_pay [DEPTH];
    logic [FU_IDX_W-1:0]     mem_fu  [DEPTH];
    logic [PTR_W-1:0]        head, tail;
    logic [CNT_W-1:0]        count;
    logic [PTR_W-1:0]        wr_idx  [WAYS];
    logic [PTR_W-1:0]        rd_idx  [WAYS];
    logic [ISS_W-1:0]        enq_n, enq_cnt, deq_n, sel_cnt;
    logic [WAYS*FU_IDX_W-1:0] cand_fu;
    logic [WAYS-1:0]         sel_mask, iss_mask;
    logic [FU_IDX_W-1:0]     ofu;

    assign InReady      = ((DEPTH - int'(count)) >= WAYS) && !DispatchFlash;
    assign DispatchStop = ~InReady;

    // Valid lanes are compacted: each lane writes at tail plus the number of valid lanes below it.
    always_comb begin
        enq_n   = '0;
        cand_fu = '0;
        for (int l = 0; l < WAYS; l++) begin
            wr_idx[l] = tail + PTR_W'(enq_n);
            if (InValid[l]) enq_n = enq_n + ISS_W'(1);
        end
        for (int i = 0; i < WAYS; i++) begin
            rd_idx[i] = head + PTR_W'(i);
            cand_fu[i*FU_IDX_W +: FU_IDX_W] = mem_fu[rd_idx[i]];
        end
    end

    dispatch_select #(
        .WAYS      (WAYS),
        .FU_NUM    (FU_NUM),
        .FU_IDX_W  (FU_IDX_W),
        .ROB_CNT_W (ROB_CNT_W),
        .CNT_W     (CNT_W),
        .ISS_W     (ISS_W)
    ) u_select (
        .cand_fu    (cand_fu),
        .fu_full    (FuFull),
        .rob_free   (RobFreeNumb),
        .count      (count),
        .issue_mask (sel_mask),
        .issue_cnt  (sel_cnt)
    );

    assign iss_mask = DispatchFlash ? '0 : sel_mask;
    assign deq_n    = DispatchFlash ? '0 : sel_cnt;
    assign enq_cnt  = InReady ? enq_n : '0;

    always_comb begin
        FuValid         = '0;
        FuPayload       = '0;
        RobAllocValid   = iss_mask;
        RobAllocPayload = '0;
        ofu             = '0;
        for (int i = 0; i < WAYS; i++) begin
            if (iss_mask[i]) begin
                ofu          = cand_fu[i*FU_IDX_W +: FU_IDX_W];
                FuValid[ofu] = 1'b1;
                FuPayload[int'(ofu)*PAYLOAD_W +: PAYLOAD_W]  = mem_pay[rd_idx[i]];
                RobAllocPayload[i*PAYLOAD_W +: PAYLOAD_W]    = mem_pay[rd_idx[i]];
            end
        end
    end

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (DispatchFlash) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            head  <= head + PTR_W'(deq_n);
            tail  <= tail + PTR_W'(enq_cnt);
            count <= count + CNT_W'(enq_cnt) - CNT_W'(deq_n);
        end
    end

    always_ff @(posedge Clk) begin
        for (int l = 0; l < WAYS; l++) begin
            if (InReady && InValid[l]) begin
                mem_pay[wr_idx[l]] <= InPayload[l*PAYLOAD_W +: PAYLOAD_W];
                mem_fu[wr_idx[l]]  <= InFu[l*FU_IDX_W +: FU_IDX_W];
            end
        end
    end

`ifdef DISPATCH_STAT_EN
    logic [31:0] rob_stall_q, rs_stall_q;
    logic        head_fu_full, stall_rob, stall_rs;

    assign head_fu_full = FuFull[cand_fu[FU_IDX_W-1:0]];
    assign stall_rs     = !DispatchFlash && (count != '0) && head_fu_full;
    assign stall_rob    = !DispatchFlash && (count != '0) && !head_fu_full && (RobFreeNumb == '0);

    always_ff @(posedge Clk or posedge Rest) begin
        if (Rest) begin
            rob_stall_q <= '0;
            rs_stall_q  <= '0;
        end else begin
            if (stall_rob && (rob_stall_q != '1)) rob_stall_q <= rob_stall_q + 32'd1;
            if (stall_rs && (rs_stall_q != '1))   rs_stall_q  <= rs_stall_q + 32'd1;
        end
    end

    assign StallRobCnt = rob_stall_q;
    assign StallRsCnt  = rs_stall_q;
`else
    assign StallRobCnt = '0;
    assign StallRsCnt  = '0;
`endif

endmodule

// File: doc/dispatch_buffer.md
# dispatch_buffer

Parametrised, in-order dispatch buffer between rename and the reservation stations / ROB. It accepts a WAYS-wide renamed bundle into a circular queue and each cycle issues up to WAYS oldest entries, strictly in program order, to per-class functional-unit ports. Issue is gated by RS-full backpressure, ROB free space and a limit of one issue per FU port per cycle. It adds buffering, partial dispatch and flush behaviour that the fixed 4-way combinational dispatch stage does not have.

## Interface
Parameters:
- WAYS, 4: bundle width in and maximum issues per cycle.
- DEPTH, 8: queue entries; power of two, at least WAYS.
- PAYLOAD_W, 96: opaque micro-op payload width (opcode, sources, physical dest, PC).
- FU_NUM, 7: number of FU issue ports.
- FU_IDX_W, 3: width of the FU class index.
- ROB_CNT_W, 7: width of the ROB free count.

Ports:
- Clk, in, 1: clock; all state updates on the rising edge.
- Rest, in, 1: reset, asynchronous, active-high.
- DispatchFlash, in, 1: synchronous flush.
- InValid, in, WAYS: lane valid; lanes need not be contiguous.
- InPayload, in, WAYS*PAYLOAD_W: lane payloads.
- InFu, in, WAYS*FU_IDX_W: target FU class per lane.
- InReady, out, 1: bundle accepted this edge when asserted.
- DispatchStop, out, 1: equal to ~InReady; upstream stall.
- RobFreeNumb, in, ROB_CNT_W: free ROB slots.
- RobAllocValid, out, WAYS: ROB write enables, in order, issue slot 0 first.
- RobAllocPayload, out, WAYS*PAYLOAD_W: payloads written into the ROB.
- FuValid, out, FU_NUM: issue strobe per FU port.
- FuPayload, out, FU_NUM*PAYLOAD_W: issued payload per port.
- FuFull, in, FU_NUM: RS full, one bit per port.
- StallRobCnt, out, 32: cycles stalled on the ROB.
- StallRsCnt, out, 32: cycles stalled on an RS.

## Operation
Queue state:
- Registers: entries, Head, Tail (log2 DEPTH bits each, wrap naturally), Count (log2 DEPTH + 1 bits).
- Next count: Count_next = Count + enq − deq.

Enqueue:
- InReady = (DEPTH − Count ≥ WAYS) && !DispatchFlash, computed from registered Count only. This is conservative; same-cycle frees are not counted.
- On accept, valid lanes are compacted in lane order and written at Tail, Tail+1, … Tail advances by popcount(InValid).
- An all-zero InValid is a no-op.

Selection:
- Candidates are slot i = Head+i, for i < min(WAYS, Count).
- Slot i issues only if all of the following hold:
  - slots 0..i−1 issue this cycle;
  - FuFull[fu] == 0;
  - no older slot this cycle targets the same fu;
  - RobFreeNumb > i.
- The first failing slot stops selection; no younger slot issues.
- For each issued slot: FuValid[fu] = 1, FuPayload[fu] = payload, RobAllocValid[i] = 1. Head advances by the number issued.

Stall counters:
- StallRobCnt increments when Count > 0 and slot 0 is blocked only by RobFreeNumb == 0.
- StallRsCnt increments when slot 0 is blocked by FuFull.
- Both saturate at all ones.

Flush:
- DispatchFlash forces FuValid = 0, RobAllocValid = 0 and InReady = 0 in the same cycle.
- At the next edge Head = Tail = Count = 0.
- Flush takes priority over enqueue and dispatch.

Reset:
- Head, Tail, Count and counters are 0.
- FuValid, RobAllocValid and DispatchStop are 0; InReady is 1.
- Payload outputs are 0.
- A Rest assertion mid-operation discards all entries immediately.

## Timing
- Bundle accepted at edge N is eligible for issue in cycle N+1; minimum latency is 1 cycle.
- FuValid, FuPayload and RobAlloc* are combinational from registered queue state, FuFull and RobFreeNumb.
- The RS and ROB capture issued entries on the same edge that Head advances.
- Full queue: InReady = 0 and DispatchStop = 1 until Count ≤ DEPTH − WAYS.
- Empty queue: no issue; counters hold.
- Wrap-around: slot indices are taken modulo DEPTH; Head = DEPTH−1 with Count = 2 issues entries DEPTH−1 and 0.

## Configuration
- DISPATCH_STAT_EN defined: stall counters are implemented as described.
- DISPATCH_STAT_EN undefined: no counter registers; StallRobCnt and StallRsCnt are tied to 0. The port list is unchanged.

## Structure
- Shared package dispatch_pkg holds:
  - FU class constants FU_ALU1=0, FU_ALU2=1, FU_BRU=2, FU_CSRU=3, FU_DIV=4, FU_MUL=5, FU_LSU=6;
  - default PAYLOAD_W and ROB_CNT_W.
- Sub-module dispatch_select: purely combinational in-order selection. Inputs are candidate FU indices, FuFull, RobFreeNumb and Count. Outputs are the issue mask and issue count.
- dispatch_buffer holds the queue, pointers, enqueue compaction, flush and counters.

## Test plan
- Reset, then bundle InValid=4'b1111 with FUs {ALU1, ALU2, BRU, LSU} and RobFreeNumb=64 -> next cycle all four FuValid bits set, RobAllocValid=4'b1111, Count returns to 0.
- Bundle FUs {ALU1, ALU1, MUL, DIV} -> cycle 1 issues slot 0 only; cycle 2 issues the remaining three.
- RobFreeNumb=2 with 4 queued -> exactly 2 issue; with DISPATCH_STAT_EN, RobFreeNumb=0 increments StallRobCnt by 1 per cycle.
- FuFull[LSU]=1 with head targeting LSU, and 8 entries enqueued over two bundles -> no issue, InReady=0, DispatchStop=1; release FuFull -> issue resumes in order.
- Head=7, Tail=1, Count=2 -> issues entries 7 then 0; pointers wrap to Head=1.
- DispatchFlash with Count=6 and a valid input bundle -> no issue or enqueue that cycle; next cycle Count=0, InReady=1.
